exp_arbiter: RTL and testbench
==============================

# exp_arbiter

Round-robin controller that shares one `exp` unit among `N_REQ` requesters, such as softmax lanes. It arbitrates the requests, issues one operand at a time to the unit, and returns each result to the requester that sent it. It also recovers the unit after reset, because `exp` has no reset of its own. The block sits between the lane logic and the single `exp` instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `MAX_INT`, default 16: largest integer magnitude passed to `exp` when clamping is compiled in.
- `GW`, default `$clog2(N_REQ)`: width of the grant index.

Ports:
- `clk`  in  1: sole clock.
- `rst`  in  1: reset; synchronous, active-high.
- `req_valid`  in  N_REQ: per-lane request valid.
- `req_data`  in  32*N_REQ: lane i operand in bits [32i+31:32i].
- `req_rdy`  out  N_REQ: one-hot accept.
- `rsp_valid`  out  N_REQ: one-hot result valid.
- `rsp_data`  out  32: result, shared across lanes.
- `rsp_rdy`  in  N_REQ: per-lane result accept.
- `exp_x`  out  32: operand to `exp`.
- `exp_i_valid`  out  1: drives `exp.i_valid`.
- `exp_o_rdy`  in  1: from `exp.o_rdy`.
- `exp_o_valid`  in  1: from `exp.o_valid`.
- `exp_i_rdy`  out  1: drives `exp.i_rdy`.
- `exp_y`  in  32: from `exp.y`.
- `grant_id`  out  GW: lane currently owning the unit.
- `busy`  out  1: high when state is not IDLE.

## Operation
- Data format is 32-bit sign-magnitude fixed point: bit 31 is the sign, [30:15] is the integer magnitude, [14:0] is the fraction.
- State machine has five states: DRAIN, IDLE, ISSUE, WAIT, RESP.
- DRAIN
  - `exp_i_rdy`=1 and `exp_i_valid`=0.
  - Any result arriving from `exp` is discarded.
  - Moves to IDLE on the first cycle with `exp_o_rdy`=1 and `exp_o_valid`=0.
- IDLE
  - Picks a winner round-robin, searching from `last_grant`+1 upward and wrapping.
  - `req_rdy[winner]` is combinational and asserted only in IDLE.
  - The transfer completes in the same cycle: latch the operand to `x_reg`, latch `grant_id`, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE
  - `exp_x`=`x_reg` and `exp_i_valid`=1.
  - Moves to WAIT on an edge where `exp_o_rdy`=1.
- WAIT
  - `exp_i_rdy`=1.
  - On `exp_o_valid`, capture `exp_y` into `rsp_reg` and go to RESP.
  - `exp` leaves its OUT state on that same edge.
- RESP
  - `rsp_valid[grant_id]`=1 and `rsp_data`=`rsp_reg`.
  - On `rsp_rdy[grant_id]`, set `last_grant`←`grant_id` and go to IDLE.
  - `rsp_rdy` bits of other lanes are ignored.
- Only one operation is in flight at a time. No lane is starved: a waiting lane is served within N_REQ grants.
- Simultaneous `req_valid` and `rst`: reset wins and the request is not accepted.
- `rsp_data` holds its value outside RESP. Its value there is unspecified but stable.

## Timing
- Reset values:
  - state=DRAIN, `last_grant`=N_REQ-1, `grant_id`=0.
  - `req_rdy`=0, `rsp_valid`=0, `rsp_data`=0, `exp_x`=0.
  - `exp_i_valid`=0, `exp_i_rdy`=1, `busy`=1.
- Reset during any operation abandons it. The aborted lane receives no response. DRAIN runs until `exp` returns to its idle state.
- Latency when `exp` is idle, `rsp_rdy` is held high and the operand integer magnitude is k:
  - accept in cycle 0, issue in cycle 1;
  - `exp_o_valid` in cycle 6+k;
  - `rsp_valid` in cycle 7+k.
- Back-to-back operation: the next accept happens in the cycle after the RESP handshake.
- Outputs are registered state decodes. The only combinational path is `req_valid`→`req_rdy`.

## Configuration
- `EXP_ARB_CLAMP_EN` defined:
  - In IDLE, an accepted operand with integer magnitude > `MAX_INT` bypasses `exp` and goes straight to RESP.
  - `rsp_reg`=0 for a negative operand; `rsp_reg`=32'h7FFF_FFFF for a positive one.
  - Accept-to-`rsp_valid` latency is 1 cycle.
  - This bounds the unit's occupancy to at most MAX_INT+6 cycles.
- `EXP_ARB_CLAMP_EN` undefined:
  - Every operand is issued unchanged.
  - `MAX_INT` is unused.

## Structure
- Shared package `tensorlog_pkg` holds:
  - the fixed-point field widths and bit positions (SIGN=31, INT=[30:15], FRAC=[14:0]);
  - FP_ONE=32'h0000_8000 and FP_MAX=32'h7FFF_FFFF;
  - the state enum.
- One sub-module, `rr_pick`, is combinational: inputs are the request vector and `last_grant`; outputs are the one-hot winner and its index.

## Test plan
- Reset release with a real `exp` instance already in INT_MULT → `busy` stays high until `exp.o_rdy`=1; the first grant happens afterwards; no spurious `rsp_valid`.
- Lane 0 sends 32'h0000_0000 → `rsp_valid[0]` in cycle 7 with `rsp_data` equal to `exp`'s output for 0, nominally 32'h0000_8000.
- Lane 2 sends 32'h0001_0000 (k=2) → `rsp_valid[2]` in cycle 9; with `rsp_rdy[2]` held low for 5 cycles, `rsp_data` stays stable until accepted.
- All four lanes hold `req_valid` with distinct operands → grants go 0,1,2,3,0; every result arrives on the correct lane.
- With `EXP_ARB_CLAMP_EN` and `MAX_INT`=16, lane 1 sends 32'h8010_0000 (-32) → `rsp_data`=0 one cycle after accept and `exp_i_valid` never asserts. Lane 3 sends 32'h0010_0000 (+32) → `rsp_data`=32'h7FFF_FFFF.
- `rst` asserted during WAIT → no response to the aborted lane; DRAIN runs, then normal grants resume starting from lane 0.

Source files
------------

// File: rtl/tensorlog_pkg.sv
// tensorlog_pkg: Q16.15 sign-magnitude field layout, FP constants and the
// exp_arbiter state enum, shared by every tensorlog block.
package tensorlog_pkg;

  localparam int FP_W     = 32;
  localparam int SIGN_BIT = 31;
  localparam int INT_MSB  = 30;
  localparam int INT_LSB  = 15;
  localparam int INT_W    = 16;
  localparam int FRAC_MSB = 14;
  localparam int FRAC_W   = 15;

  localparam logic [FP_W-1:0] FP_ONE = 32'h0000_8000;
  localparam logic [FP_W-1:0] FP_MAX = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  function automatic logic [INT_W-1:0] fp_int(
    input logic [FP_W-1:0] x
  );
    return x[INT_MSB:INT_LSB];
  endfunction

endpackage

// File: rtl/exp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick starting at last_grant+1.
// Ports: req (requests), last_grant -> win (one-hot), win_id (index).
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [N_REQ-1:0] win,
  output logic [GW-1:0]    win_id
);

  function automatic logic [GW-1:0] wrap_idx(
    input logic [GW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return GW'(s);
  endfunction

  // Scan from lowest to highest priority so
  // the nearest requester after last_grant wins.
  always_comb begin
    win    = '0;
    win_id = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[wrap_idx(last_grant, i)]) begin
        win_id = wrap_idx(last_grant, i);
      end
    end
    if (|req) win[win_id] = 1'b1;
  end

endmodule

// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin sharing of one exp unit among N_REQ lanes,
// with post-reset drain of the unit. Optional macro: EXP_ARB_CLAMP_EN.
// Ports: clk, rst (sync, high); req_valid/req_data/req_rdy lane requests;
// rsp_valid/rsp_data/rsp_rdy lane results; exp_x/exp_i_valid/exp_o_rdy,
// exp_o_valid/exp_i_rdy/exp_y to the exp unit; grant_id, busy status.
module exp_arbiter
  import tensorlog_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_INT = 16,
  parameter int GW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [32*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_rdy,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [31:0]        rsp_data,
  input  logic [N_REQ-1:0]   rsp_rdy,
  output logic [31:0]        exp_x,
  output logic               exp_i_valid,
  input  logic               exp_o_rdy,
  input  logic               exp_o_valid,
  output logic               exp_i_rdy,
  input  logic [31:0]        exp_y,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

`ifdef EXP_ARB_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  arb_state_e        state;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     grant_q;
  logic [31:0]       x_reg;
  logic [31:0]       rsp_reg;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic              exp_i_valid_q;
  logic              exp_i_rdy_q;
  logic              busy_q;

  logic [N_REQ-1:0]  win;
  logic [GW-1:0]     win_id;
  logic [31:0]       lane_op [N_REQ];
  logic [31:0]       op;
  logic              clamp;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_op[g] = req_data[32*g +: 32];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .win        (win),
    .win_id     (win_id)
  );

  assign op    = lane_op[win_id];
  assign clamp = CLAMP_EN &&
                 (int'(fp_int(op)) > MAX_INT);

  // Reset blocks the handshake so a request
  // coincident with rst is never accepted.
  assign req_rdy = (state == ST_IDLE && !rst)
                 ? win : '0;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_reg;
  assign exp_x       = x_reg;
  assign exp_i_valid = exp_i_valid_q;
  assign exp_i_rdy   = exp_i_rdy_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_DRAIN;
      last_grant    <= GW'(N_REQ-1);
      grant_q       <= '0;
      x_reg         <= '0;
      rsp_reg       <= '0;
      rsp_valid_q   <= '0;
      exp_i_valid_q <= 1'b0;
      exp_i_rdy_q   <= 1'b1;
      busy_q        <= 1'b1;
    end else begin
      unique case (state)
        ST_DRAIN: begin
          // exp has no reset: swallow any stale
          // result until it is idle again.
          if (exp_o_rdy && !exp_o_valid) begin
            state       <= ST_IDLE;
            exp_i_rdy_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (|win) begin
            x_reg   <= op;
            grant_q <= win_id;
            busy_q  <= 1'b1;
            if (clamp) begin
              state       <= ST_RESP;
              rsp_valid_q <= win;
              rsp_reg     <= op[SIGN_BIT]
                           ? '0 : FP_MAX;
            end else begin
              state         <= ST_ISSUE;
              exp_i_valid_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (exp_o_rdy) begin
            state         <= ST_WAIT;
            exp_i_valid_q <= 1'b0;
            exp_i_rdy_q   <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (exp_o_valid) begin
            state       <= ST_RESP;
            rsp_reg     <= exp_y;
            exp_i_rdy_q <= 1'b0;
            rsp_valid_q <= ONE << grant_q;
          end
        end
        ST_RESP: begin
          if (rsp_rdy[grant_q]) begin
            state       <= ST_IDLE;
            last_grant  <= grant_q;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state <= ST_DRAIN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_arbiter.sv
// tb_exp_arbiter: self-checking bench for exp_arbiter with a
// reset-less behavioural exp unit and a response scoreboard.
module tb_exp_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_rdy;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic [3:0]   rsp_rdy;
  logic [31:0]  exp_x;
  logic         exp_i_valid;
  logic         exp_o_rdy;
  logic         exp_o_valid;
  logic         exp_i_rdy;
  logic [31:0]  exp_y;
  logic [1:0]   grant_id;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          lane;
    logic [31:0] y;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  exp_arbiter #(
    .N_REQ   (4),
    .MAX_INT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_rdy     (req_rdy),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_rdy     (rsp_rdy),
    .exp_x       (exp_x),
    .exp_i_valid (exp_i_valid),
    .exp_o_rdy   (exp_o_rdy),
    .exp_o_valid (exp_o_valid),
    .exp_i_rdy   (exp_i_rdy),
    .exp_y       (exp_y),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  function automatic logic [31:0] exp_ref(input logic [31:0] x);
    return (x == 32'h0) ? 32'h0000_8000 : (x ^ 32'h1357_9BDF);
  endfunction

  function automatic int k_of(input logic [31:0] x);
    return int'(x[30:15]);
  endfunction

  // Behavioural exp: no reset, powers up mid-computation.
  typedef enum {M_IDLE, M_MULT, M_OUT} m_e;
  m_e          ms   = M_MULT;
  int          mcnt = 12;
  logic [31:0] my   = 32'hDEAD_BEEF;

  always @(posedge clk) begin
    case (ms)
      M_IDLE: if (exp_i_valid) begin
        ms   <= M_MULT;
        mcnt <= 4 + k_of(exp_x);
        my   <= exp_ref(exp_x);
      end
      M_MULT: if (mcnt <= 1) ms <= M_OUT;
              else mcnt <= mcnt - 1;
      M_OUT:  if (exp_i_rdy) ms <= M_IDLE;
      default: ms <= M_IDLE;
    endcase
  end

  assign exp_o_rdy   = (ms == M_IDLE);
  assign exp_o_valid = (ms == M_OUT);
  assign exp_y       = my;

  task automatic test_reset();
    int c;
    bit seen_idle;
    rst = 1'b1; req_valid = '0; rsp_rdy = 4'hF; req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 4'h0 || req_rdy !== 4'h0 ||
        exp_i_valid !== 1'b0 || exp_i_rdy !== 1'b1 || grant_id !== 2'd0 ||
        rsp_data !== 32'h0 || exp_x !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: busy=%b rspv=%b rdy=%b iv=%b ir=%b gid=%0d rd=%h x=%h, want 1 0000 0000 0 1 0 0 0",
               busy, rsp_valid, req_rdy, exp_i_valid, exp_i_rdy, grant_id, rsp_data, exp_x);
    end
    rst = 1'b0;
    req_valid = 4'b0001;
    #1;
    c = 0; seen_idle = 0;
    while (req_rdy == 4'h0 && c < 200) begin
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 4'h0) begin
        errors++;
        $display("FAIL drain_busy: busy=%b rspv=%b, want 1 0000", busy, rsp_valid);
      end
      if (exp_o_rdy && !exp_o_valid) seen_idle = 1;
      @(negedge clk); c++;
    end
    checks++;
    if (!seen_idle || req_rdy !== 4'b0001 || c < 5) begin
      errors++;
      $display("FAIL first_grant: rdy=%b seen_idle=%0d cycles=%0d, want 0001 1 >=5",
               req_rdy, seen_idle, c);
    end
    req_valid = 4'h0;
  endtask

  task automatic test_lane0();
    sb_t e;
    int  cyc;
    @(negedge clk);
    req_data[31:0] = 32'h0; req_valid = 4'b0001; rsp_rdy = 4'hF;
    #1;
    checks++;
    if (req_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL lane0_accept: rdy=%b, want 0001", req_rdy);
    end
    sb.push_back('{lane: 0, y: exp_ref(32'h0)});
    @(negedge clk);
    req_valid = 4'h0; cyc = 1;
    checks++;
    if (exp_i_valid !== 1'b1 || exp_x !== 32'h0) begin
      errors++;
      $display("FAIL lane0_issue: iv=%b x=%h, want 1 0", exp_i_valid, exp_x);
    end
    while (rsp_valid === 4'h0 && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    e = sb.pop_front();
    checks++;
    if (cyc != 7 || rsp_valid !== 4'b0001 || rsp_data !== e.y) begin
      errors++;
      $display("FAIL lane0_rsp: cyc=%0d v=%b d=%h, want 7 0001 %h",
               cyc, rsp_valid, rsp_data, e.y);
    end
  endtask

  task automatic test_lane2_stall();
    sb_t         e;
    int          cyc;
    logic [31:0] held;
    @(negedge clk);
    req_data[95:64] = 32'h0001_0000; req_valid = 4'b0100; rsp_rdy = 4'b1011;
    #1;
    checks++;
    if (req_rdy !== 4'b0100) begin
      errors++;
      $display("FAIL lane2_accept: rdy=%b, want 0100", req_rdy);
    end
    sb.push_back('{lane: 2, y: exp_ref(32'h0001_0000)});
    @(negedge clk);
    req_valid = 4'h0; cyc = 1;
    while (rsp_valid === 4'h0 && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    e = sb.pop_front();
    checks++;
    if (cyc != 9 || rsp_valid !== 4'b0100 || rsp_data !== e.y) begin
      errors++;
      $display("FAIL lane2_rsp: cyc=%0d v=%b d=%h, want 9 0100 %h",
               cyc, rsp_valid, rsp_data, e.y);
    end
    held = e.y;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== held) begin
        errors++;
        $display("FAIL lane2_hold: v=%b d=%h, want 0100 %h", rsp_valid, rsp_data, held);
      end
    end
    rsp_rdy = 4'hF;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'h0 || busy !== 1'b0 || rsp_data !== held) begin
      errors++;
      $display("FAIL lane2_release: v=%b busy=%b d=%h, want 0000 0 %h",
               rsp_valid, busy, rsp_data, held);
    end
  endtask

  task automatic test_round_robin();
    sb_t e;
    int  w;
    int  cyc;
    int  order [5] = '{0, 1, 2, 3, 0};
    // Serve lane 3 alone so the rotation restarts at lane 0.
    @(negedge clk);
    req_data[127:96] = 32'h0000_8600; req_valid = 4'b1000; rsp_rdy = 4'hF;
    #1;
    checks++;
    if (req_rdy !== 4'b1000) begin
      errors++;
      $display("FAIL rr_prime: rdy=%b, want 1000", req_rdy);
    end
    sb.push_back('{lane: 3, y: exp_ref(32'h0000_8600)});
    @(negedge clk);
    req_valid = 4'h0;
    cyc = 0;
    while (rsp_valid === 4'h0 && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_data !== e.y) begin
      errors++;
      $display("FAIL rr_prime_rsp: v=%b d=%h, want 1000 %h", rsp_valid, rsp_data, e.y);
    end
    @(negedge clk);
    req_data = {32'h0001_8400, 32'h0001_0300, 32'h0000_8200, 32'h0000_0100};
    req_valid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (req_rdy === 4'h0 && w < 50) begin
        @(negedge clk); w++;
      end
      checks++;
      if (req_rdy !== (4'b0001 << order[g]) || w != 0) begin
        errors++;
        $display("FAIL rr_grant%0d: rdy=%b wait=%0d, want %b 0",
                 g, req_rdy, w, 4'b0001 << order[g]);
      end
      sb.push_back('{lane: order[g], y: exp_ref(req_data[32*order[g] +: 32])});
      @(negedge clk);
      req_data[32*order[g] +: 32] = 32'h0000_1000 + 32'(order[g]);
      if (g == 4) req_valid = 4'h0;
      cyc = 0;
      while (rsp_valid === 4'h0 && cyc < 100) begin
        @(negedge clk); cyc++;
      end
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== (4'b0001 << e.lane) || rsp_data !== e.y) begin
        errors++;
        $display("FAIL rr_rsp%0d: v=%b d=%h, want %b %h",
                 g, rsp_valid, rsp_data, 4'b0001 << e.lane, e.y);
      end
      @(negedge clk);
    end
  endtask

`ifdef EXP_ARB_CLAMP_EN
  task automatic test_clamp();
    bit saw_iv;
    saw_iv = 0;
    @(negedge clk);
    req_data[63:32] = 32'h8010_0000; req_valid = 4'b0010; rsp_rdy = 4'hF;
    #1;
    checks++;
    if (req_rdy !== 4'b0010) begin
      errors++;
      $display("FAIL clamp_neg_accept: rdy=%b, want 0010", req_rdy);
    end
    if (exp_i_valid) saw_iv = 1;
    @(negedge clk);
    req_valid = 4'h0;
    if (exp_i_valid) saw_iv = 1;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL clamp_neg_rsp: v=%b d=%h, want 0010 0", rsp_valid, rsp_data);
    end
    @(negedge clk);
    req_data[127:96] = 32'h0010_0000; req_valid = 4'b1000;
    #1;
    if (exp_i_valid) saw_iv = 1;
    @(negedge clk);
    req_valid = 4'h0;
    if (exp_i_valid) saw_iv = 1;
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 32'h7FFF_FFFF || saw_iv) begin
      errors++;
      $display("FAIL clamp_pos_rsp: v=%b d=%h iv_seen=%0d, want 1000 7fffffff 0",
               rsp_valid, rsp_data, saw_iv);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_in_wait();
    sb_t e;
    int  c;
    @(negedge clk);
    req_data[95:64] = 32'h0001_8000; req_valid = 4'b0100; rsp_rdy = 4'hF;
    #1;
    checks++;
    if (req_rdy !== 4'b0100) begin
      errors++;
      $display("FAIL rw_accept: rdy=%b, want 0100", req_rdy);
    end
    @(negedge clk);
    req_valid = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || exp_i_rdy !== 1'b1 || exp_i_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_in_wait: busy=%b ir=%b iv=%b, want 1 1 0",
               busy, exp_i_rdy, exp_i_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_data[31:0] = 32'h0000_8000;
    req_valid = 4'b0101;
    #1;
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL rw_reset_state: busy=%b gid=%0d d=%h, want 1 0 0",
               busy, grant_id, rsp_data);
    end
    c = 0;
    while (req_rdy === 4'h0 && c < 200) begin
      checks++;
      if (rsp_valid !== 4'h0) begin
        errors++;
        $display("FAIL rw_no_rsp: v=%b, want 0000", rsp_valid);
      end
      @(negedge clk); c++;
    end
    checks++;
    if (req_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL rw_resume: rdy=%b, want 0001", req_rdy);
    end
    sb.push_back('{lane: 0, y: exp_ref(32'h0000_8000)});
    @(negedge clk);
    req_valid = 4'h0;
    c = 0;
    while (rsp_valid === 4'h0 && c < 100) begin
      @(negedge clk); c++;
    end
    e = sb.pop_front();
    checks++;
    if (c != 7 || rsp_valid !== 4'b0001 || rsp_data !== e.y) begin
      errors++;
      $display("FAIL rw_rsp: cyc=%0d v=%b d=%h, want 7 0001 %h",
               c + 1, rsp_valid, rsp_data, e.y);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lane0();
    test_lane2_stall();
    test_round_robin();
`ifdef EXP_ARB_CLAMP_EN
    test_clamp();
`endif
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
